// File: rtl/pe_out_drain_if.sv
// Output stream bundle: valid/ready word stream with end-of-row marker.
// master drives valid/data/last and samples ready; slave is the mirror.
interface pe_out_drain_if #(
  parameter int W = 32
);
  logic         valid;
  logic         ready;
  logic         last;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

// File: rtl/pe_out_drain.sv
// Deskews PE-array bottom results, narrows them, ping-pong buffers a row
// and streams it one column per beat.
// Ports: clk, rst (async high), capture_in, bottom_in, m (stream master),
// buf_free, overflow (sticky), sat_flag (sticky).
module pe_out_drain #(
  parameter int COLS         = 16,
  parameter int BOTTOM_WIDTH = 48,
  parameter int OUT_WIDTH    = 32,
  parameter bit SAT_EN       = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         capture_in,
  input  logic [COLS*BOTTOM_WIDTH-1:0] bottom_in,
  pe_out_drain_if.master               m,
  output logic                         buf_free,
  output logic                         overflow,
  output logic                         sat_flag
);

  localparam int BW = BOTTOM_WIDTH;
  localparam int OW = OUT_WIDTH;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] LASTC = CW'(COLS - 1);

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  // Returns {clamped, word}.
  function automatic logic [OW:0] f_narrow(
    input logic [BW-1:0] x
  );
    logic [BW-OW:0] hi;
    hi = x[BW-1:OW-1];
    if (!SAT_EN || hi == '0 || hi == '1)
      return {1'b0, x[OW-1:0]};
    else if (x[BW-1])
      return {2'b11, {(OW-1){1'b0}}};
    else
      return {2'b10, {(OW-1){1'b1}}};
  endfunction

  state_t        r_state, w_state;
  logic [CW-1:0] r_col, w_col;
  logic          r_valid, w_valid;
  logic          r_last, w_last;
  logic [OW-1:0] r_data, w_data;
  logic          r_rd, w_rd;
  logic          r_wp;
  logic [1:0]    r_alloc, w_alloc_n;
  logic [1:0]    r_full, w_full_n;
  logic          w_free;
  logic          w_acc;
  logic          w_sat;

  // Tag pipeline: stage 0 is the capture itself.
  logic [COLS-1:1] r_tv, r_ti;
  logic [COLS-1:0] w_tv, w_ti;

  logic [OW:0]   w_nar [COLS];
  logic [OW-1:0] r_buf [2][COLS];

  assign buf_free = ~&r_alloc;
  assign w_acc    = capture_in & buf_free;
  assign w_tv     = {r_tv, w_acc};
  assign w_ti     = {r_ti, r_wp};

  assign m.valid = r_valid;
  assign m.data  = r_data;
  assign m.last  = r_last;

  always_comb begin
    w_sat = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      w_nar[c] = f_narrow(bottom_in[c*BW +: BW]);
      w_sat    = w_sat | (w_tv[c] & w_nar[c][OW]);
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < COLS; c++)
      if (w_tv[c])
        r_buf[w_ti[c]][c] <= w_nar[c][OW-1:0];
  end

  always_comb begin
    w_state = r_state;
    w_col   = r_col;
    w_valid = r_valid;
    w_data  = r_data;
    w_last  = r_last;
    w_rd    = r_rd;
    w_free  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_full[r_rd]) begin
          w_state = S_DRAIN;
          w_col   = '0;
          w_valid = 1'b1;
          w_data  = r_buf[r_rd][0];
          w_last  = (COLS == 1);
        end
      end
      S_DRAIN: begin
        if (r_valid && m.ready) begin
          if (r_col == LASTC) begin
            w_free = 1'b1;
            w_rd   = ~r_rd;
            w_col  = '0;
            // Other row already complete: chain without a bubble.
            if (r_full[~r_rd]) begin
              w_data = r_buf[~r_rd][0];
              w_last = (COLS == 1);
            end else begin
              w_state = S_IDLE;
              w_valid = 1'b0;
              w_last  = 1'b0;
            end
          end else begin
            w_col  = r_col + CW'(1);
            w_data = r_buf[r_rd][w_col];
            w_last = (w_col == LASTC);
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_alloc_n = r_alloc;
    w_full_n  = r_full;
    if (w_acc)
      w_alloc_n[r_wp] = 1'b1;
    if (w_tv[COLS-1])
      w_full_n[w_ti[COLS-1]] = 1'b1;
    if (w_free) begin
      w_alloc_n[r_rd] = 1'b0;
      w_full_n[r_rd]  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_col    <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_last   <= 1'b0;
      r_rd     <= 1'b0;
      r_wp     <= 1'b0;
      r_alloc  <= '0;
      r_full   <= '0;
      r_tv     <= '0;
      r_ti     <= '0;
      overflow <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_col    <= w_col;
      r_valid  <= w_valid;
      r_data   <= w_data;
      r_last   <= w_last;
      r_rd     <= w_rd;
      r_alloc  <= w_alloc_n;
      r_full   <= w_full_n;
      r_tv     <= w_tv[COLS-2:0];
      r_ti     <= w_ti[COLS-2:0];
      if (w_acc)
        r_wp <= ~r_wp;
      if (capture_in && !buf_free)
        overflow <= 1'b1;
      if (w_sat)
        sat_flag <= 1'b1;
    end
  end

endmodule
